// File: rtl/set_time_pkg.sv
// Shared definitions for the time-set controller.
// Field selector codes, field limits and widths, the repeat-phase type used by the
// pushbutton conditioner, and the wrap/clamp helpers used by the top level.
package set_time_pkg;

  localparam logic [1:0] FIELD_H    = 2'd0;
  localparam logic [1:0] FIELD_M    = 2'd1;
  localparam logic [1:0] FIELD_S    = 2'd2;
  localparam logic [1:0] FIELD_NONE = 2'd3;

  localparam int unsigned H_MAX  = 23;
  localparam int unsigned MS_MAX = 59;
  localparam int unsigned H_W    = 5;
  localparam int unsigned MS_W   = 6;

  // Auto-repeat waits REPEAT_DELAY after the first step, then REPEAT_RATE between steps.
  typedef enum logic {
    RepFirst,
    RepPeriodic
  } rep_phase_e;

  // One step up or down with wrap-around inside 0..max_val.
  function automatic logic [MS_W-1:0] wrap_step(input logic [MS_W-1:0] val,
                                                input logic [MS_W-1:0] max_val,
                                                input logic            up);
    if (up) begin
      return (val == max_val) ? '0 : val + 1'b1;
    end
    return (val == '0) ? max_val : val - 1'b1;
  endfunction

  function automatic logic [MS_W-1:0] clamp_val(input logic [MS_W-1:0] val,
                                                input logic [MS_W-1:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter and auto-repeat.
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   pb_i       raw asynchronous, bouncy button
//   inhibit_i  both buttons debounced-high: freeze the repeat counter
//   req_o      one-cycle step request (debounced press, then repeats while held)
//   level_o    debounced button level
module pb_conditioner
  import set_time_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pb_i,
  input  logic inhibit_i,
  output logic req_o,
  output logic level_o
);

  // Counters only need to reach (limit - 1); the limit itself triggers the action.
  localparam int unsigned DbW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned RepW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  logic [1:0]      sync_q;
  logic            deb_q, deb_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic [RepW-1:0] rep_last;
  rep_phase_e      rep_phase_q, rep_phase_d;
  logic            req_q, req_d;
  logic            sync;
  logic            rise;

  assign sync     = sync_q[1];
  assign rep_last = (rep_phase_q == RepFirst) ? RepW'(REPEAT_DELAY - 1) :
                                                RepW'(REPEAT_RATE - 1);

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync != deb_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
        deb_d = sync;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    rise = deb_d & ~deb_q;

    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    req_d       = rise;
    if (!deb_d || rise) begin
      // Release (or a fresh press) restarts the repeat schedule.
      rep_cnt_d   = '0;
      rep_phase_d = RepFirst;
    end else if (REPEAT_EN && !inhibit_i) begin
      if (rep_cnt_q == rep_last) begin
        req_d       = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = RepPeriodic;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      deb_q       <= 1'b0;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_phase_q <= RepFirst;
      req_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pb_i};
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      req_q       <= req_d;
    end
  end

  assign req_o   = req_q;
  assign level_o = deb_q;

endmodule

// File: rtl/set_time_ctrl.sv
// Time-set controller: turns increment/decrement buttons and a field selector into
// hours/minutes/seconds preset values, with per-field wrap and a load of the running time.
// Ports:
//   clk, reset (synchronous, active low)
//   pb_inc, pb_dec       raw buttons
//   field_sel            0 hours, 1 minutes, 2 seconds, 3 none
//   load, cur_h/m/s      copy (clamped) running time into the presets
//   h_out, m_out, s_out  registered preset values
//   step                 one-cycle pulse when the presets change by a step or a load
module set_time_ctrl
  import set_time_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pb_inc,
  input  logic            pb_dec,
  input  logic [1:0]      field_sel,
  input  logic            load,
  input  logic [H_W-1:0]  cur_h,
  input  logic [MS_W-1:0] cur_m,
  input  logic [MS_W-1:0] cur_s,
  output logic [H_W-1:0]  h_out,
  output logic [MS_W-1:0] m_out,
  output logic [MS_W-1:0] s_out,
  output logic            step
);

  logic inc_req, inc_level;
  logic dec_req, dec_level;
  logic both_held;
  logic inc_go, dec_go;

  logic [H_W-1:0]  h_q, h_d;
  logic [MS_W-1:0] m_q, m_d;
  logic [MS_W-1:0] s_q, s_d;
  logic            step_q, step_d;

  assign both_held = inc_level & dec_level;

  pb_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_EN   (REPEAT_EN)
  ) u_inc (
    .clk_i    (clk),
    .rst_ni   (reset),
    .pb_i     (pb_inc),
    .inhibit_i(both_held),
    .req_o    (inc_req),
    .level_o  (inc_level)
  );

  pb_conditioner #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_EN   (REPEAT_EN)
  ) u_dec (
    .clk_i    (clk),
    .rst_ni   (reset),
    .pb_i     (pb_dec),
    .inhibit_i(both_held),
    .req_o    (dec_req),
    .level_o  (dec_level)
  );

  // A request is honoured only while the other button is debounced-low.
  assign inc_go = inc_req & ~dec_level;
  assign dec_go = dec_req & ~inc_level;

  always_comb begin
    h_d    = h_q;
    m_d    = m_q;
    s_d    = s_q;
    step_d = 1'b0;
    if (load) begin
      h_d    = H_W'(clamp_val(MS_W'(cur_h), MS_W'(H_MAX)));
      m_d    = clamp_val(cur_m, MS_W'(MS_MAX));
      s_d    = clamp_val(cur_s, MS_W'(MS_MAX));
      step_d = 1'b1;
    end else if ((inc_go || dec_go) && (field_sel != FIELD_NONE)) begin
      step_d = 1'b1;
      unique case (field_sel)
        FIELD_H: h_d = H_W'(wrap_step(MS_W'(h_q), MS_W'(H_MAX), inc_go));
        FIELD_M: m_d = wrap_step(m_q, MS_W'(MS_MAX), inc_go);
        FIELD_S: s_d = wrap_step(s_q, MS_W'(MS_MAX), inc_go);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q    <= '0;
      m_q    <= '0;
      s_q    <= '0;
      step_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      m_q    <= m_d;
      s_q    <= s_d;
      step_q <= step_d;
    end
  end

  assign h_out = h_q;
  assign m_out = m_q;
  assign s_out = s_q;
  assign step  = step_q;

endmodule

// File: tb/tb_set_time_ctrl.sv
// Bench for set_time_ctrl: two instances (auto-repeat on / off) share all inputs.
// Expected presets and step cycles are derived from press start/length and pushed into
// per-instance queues; a negedge monitor pops and compares on every step pulse.
module tb_set_time_ctrl;

  localparam int Deb  = 4;
  localparam int Dly  = 16;
  localparam int Rate = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pb_inc = 1'b0;
  logic       pb_dec = 1'b0;
  logic       load = 1'b0;
  logic [1:0] field_sel = 2'd0;
  logic [4:0] cur_h = 5'd0;
  logic [5:0] cur_m = 6'd0;
  logic [5:0] cur_s = 6'd0;

  logic [4:0] h_o [2];
  logic [5:0] m_o [2];
  logic [5:0] s_o [2];
  logic       st_o[2];

  set_time_ctrl #(
    .DEBOUNCE_CYC(Deb), .REPEAT_DELAY(Dly), .REPEAT_RATE(Rate), .REPEAT_EN(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .pb_inc(pb_inc), .pb_dec(pb_dec), .field_sel(field_sel),
    .load(load), .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .h_out(h_o[0]), .m_out(m_o[0]), .s_out(s_o[0]), .step(st_o[0])
  );

  set_time_ctrl #(
    .DEBOUNCE_CYC(Deb), .REPEAT_DELAY(Dly), .REPEAT_RATE(Rate), .REPEAT_EN(1'b0)
  ) u_dut_norep (
    .clk(clk), .reset(reset), .pb_inc(pb_inc), .pb_dec(pb_dec), .field_sel(field_sel),
    .load(load), .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .h_out(h_o[1]), .m_out(m_o[1]), .s_out(s_o[1]), .step(st_o[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int h;
    int m;
    int s;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   mh[2];
  int   mm[2];
  int   ms[2];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic chk_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_h%0d", tag, i), int'(h_o[i]), mh[i]);
      chk($sformatf("%s_m%0d", tag, i), int'(m_o[i]), mm[i]);
      chk($sformatf("%s_s%0d", tag, i), int'(s_o[i]), ms[i]);
    end
  endtask

  task automatic push_exp(input int i, input int c);
    exp_t e;
    e.cyc = c;
    e.h   = mh[i];
    e.m   = mm[i];
    e.s   = ms[i];
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic model_step(input int i, input int field, input bit up);
    case (field)
      0: mh[i] = up ? (mh[i] + 1) % 24 : (mh[i] + 23) % 24;
      1: mm[i] = up ? (mm[i] + 1) % 60 : (mm[i] + 59) % 60;
      2: ms[i] = up ? (ms[i] + 1) % 60 : (ms[i] + 59) % 60;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0;
      mm[i] = 0;
      ms[i] = 0;
    end
  endtask

  // Called just after a posedge. A clean press of plen cycles yields steps at offsets
  // 0, Dly, Dly+Rate, ... below plen (only offset 0 without repeat), Deb+2 after E0.
  task automatic press(input bit inc, input bit dec, input int plen, input int gap);
    int e0;
    int k;
    e0 = cyc + 1;
    if (!(inc && dec) && field_sel != 2'd3) begin
      for (int i = 0; i < 2; i++) begin
        k = 0;
        while (k < plen) begin
          model_step(i, int'(field_sel), inc);
          push_exp(i, e0 + Deb + 2 + k);
          if (i == 0) k = (k == 0) ? Dly : k + Rate;
          else k = plen;
        end
      end
    end
    pb_inc = inc;
    pb_dec = dec;
    repeat (plen) @(posedge clk);
    #1;
    pb_inc = 1'b0;
    pb_dec = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    cur_h = 5'(h);
    cur_m = 6'(m);
    cur_s = 6'(s);
    load  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mh[i] = (h > 23) ? 23 : h;
      mm[i] = (m > 59) ? 59 : m;
      ms[i] = (s > 59) ? 59 : s;
      push_exp(i, cyc + 1);
    end
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic glitch(input bit inc, input int len);
    pb_inc = inc;
    pb_dec = ~inc;
    repeat (len) @(posedge clk);
    #1;
    pb_inc = 1'b0;
    pb_dec = 1'b0;
    repeat (2 * Deb + 4) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int i, input logic st, input logic [4:0] h, input logic [5:0] m,
                     input logic [5:0] s);
    exp_t e;
    int   n;
    n = (i == 0) ? q0.size() : q1.size();
    if (st) begin
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL unexpected_step inst=%0d cyc=%0d actual=%0d:%0d:%0d required=no step",
                 i, cyc, h, m, s);
      end else begin
        if (i == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (e.cyc != cyc || e.h != int'(h) || e.m != int'(m) || e.s != int'(s)) begin
          failures++;
          $display("FAIL step_value inst=%0d actual=cyc%0d %0d:%0d:%0d required=cyc%0d %0d:%0d:%0d",
                   i, cyc, h, m, s, e.cyc, e.h, e.m, e.s);
        end
      end
    end else if (n > 0) begin
      if (i == 0) e = q0[0];
      else e = q1[0];
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        $display("FAIL missed_step inst=%0d actual=no step by cyc%0d required=cyc%0d %0d:%0d:%0d",
                 i, cyc, e.cyc, e.h, e.m, e.s);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, st_o[0], h_o[0], m_o[0], s_o[0]);
    mon(1, st_o[1], h_o[1], m_o[1], s_o[1]);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    int plen;
    int gap;
    int e0;
    model_reset();

    // Reset held with button and load active.
    reset  = 1'b0;
    pb_inc = 1'b1;
    load   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk_outs("reset");
      chk("reset_step", int'(st_o[0]), 0);
    end
    pb_inc = 1'b0;
    load   = 1'b0;
    reset  = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Eight clean presses on hours, then a short glitch.
    field_sel = 2'd0;
    for (int p = 0; p < 8; p++) press(1'b1, 1'b0, 10, 10);
    chk("hours_after_8", int'(h_o[0]), 8);
    glitch(1'b1, 3);
    chk_outs("after_glitch");

    // Field wrap-around without carry.
    do_load(23, 0, 59);
    field_sel = 2'd0;
    press(1'b1, 1'b0, 8, 12);
    field_sel = 2'd1;
    press(1'b0, 1'b1, 8, 12);
    field_sel = 2'd2;
    press(1'b1, 1'b0, 8, 12);
    chk_outs("wrap");
    chk("wrap_h", int'(h_o[0]), 0);
    chk("wrap_m", int'(m_o[0]), 59);

    // Long hold on seconds: repeats on one instance only.
    do_load(0, 0, 0);
    field_sel = 2'd2;
    press(1'b1, 1'b0, 34, 14);
    chk("repeat_s", int'(s_o[0]), 6);
    chk("norepeat_s", int'(s_o[1]), 1);

    // Both buttons together.
    press(1'b1, 1'b1, 30, 14);
    chk_outs("both");

    // Load coinciding with an inc step.
    field_sel = 2'd0;
    pb_inc = 1'b1;
    repeat (Deb + 2) @(posedge clk);
    #1;
    do_load(12, 34, 56);
    repeat (3) @(posedge clk);
    #1;
    pb_inc = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk_outs("load_vs_step");

    do_load(7, 63, 10);
    chk("clamp_m", int'(m_o[0]), 59);

    // Reset in the middle of a hold.
    do_load(5, 10, 20);
    field_sel = 2'd0;
    e0 = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, 0, 1'b1);
      push_exp(i, e0 + Deb + 2);
    end
    pb_inc = 1'b1;
    repeat (Deb + 5) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("midhold_reset");
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, 0, 1'b1);
      push_exp(i, cyc + 1 + Deb + 2);
    end
    repeat (8) @(posedge clk);
    #1;
    pb_inc = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("post_reset_h", int'(h_o[0]), 1);

    // Randomised mix.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 9));
      if (op < 6) begin
        field_sel = 2'($urandom_range(0, 3));
        plen = int'($urandom_range(Deb, 40));
        gap  = int'($urandom_range(2 * Deb + 2, 16));
        if (op == 5) press(1'b1, 1'b1, plen, gap);
        else if (op < 3) press(1'b1, 1'b0, plen, gap);
        else press(1'b0, 1'b1, plen, gap);
      end else if (op < 8) begin
        do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 63)));
        repeat (2) @(posedge clk);
        #1;
      end else begin
        glitch(op[0], int'($urandom_range(1, Deb - 1)));
      end
      chk_outs($sformatf("rand%0d", n));
    end

    repeat (40) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk_outs("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
